// File: rtl/capture_bus_writer.sv
// Capture bus writer: takes a sample stream and writes it word by word into a bus-mapped window.
// Optional circular capture is enabled with the CAPTURE_WRAP_EN macro; by default capture stops after one full window.
module capture_bus_writer #(
    parameter logic [31:0] BASE    = 32'h0,
    parameter int          LOGSIZE = 16,
    parameter int          TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               sample_valid,
    input  logic [31:0]        sample_data,
    output logic               sample_ready,
    output logic [31:0]        bus_addr,
    output logic [31:0]        bus_wr_data,
    output logic [3:0]         bus_be,
    output logic               bus_we,
    output logic               bus_re,
    input  logic               bus_wr_ack,
    output logic [LOGSIZE-3:0] wr_ptr,
    output logic               busy,
    output logic               wrapped,
    output logic               done,
    output logic               err,
    output logic [2:0]         state_dbg
);

    localparam int PW = LOGSIZE - 2;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] PTR_MAX = '1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_WRITE, S_ACK, S_DONE, S_ERR
    } state_t;

    state_t        state, state_next;
    logic [TW-1:0] tcnt;
    logic          ptr_last;
    logic          accept;
    logic          can_start;

    // Handshake: a sample transfers on a rising edge where sample_valid and
    // sample_ready are both high; upstream holds sample_data until then.
    assign sample_ready = (state == S_ARMED);
    assign accept       = sample_ready && sample_valid;
    assign can_start    = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
    assign ptr_last     = (wr_ptr == PTR_MAX);

    assign bus_we    = (state == S_WRITE);
    assign bus_be    = (state == S_WRITE) ? 4'hF : 4'h0;
    assign bus_re    = 1'b0;
    assign busy      = (state == S_ARMED) || (state == S_WRITE) || (state == S_ACK);
    assign done      = (state == S_DONE);
    assign err       = (state == S_ERR);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_next = S_ARMED;
            end
            S_ARMED: begin
                if (sample_valid) state_next = S_WRITE;
            end
            S_WRITE: state_next = S_ACK;
            S_ACK: begin
                if (bus_wr_ack) begin
`ifdef CAPTURE_WRAP_EN
                    state_next = S_ARMED;
`else
                    state_next = ptr_last ? S_DONE : S_ARMED;
`endif
                end else if (tcnt == TO_LAST) begin
                    state_next = S_ERR;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Address and data are registered at acceptance so they stay stable through ACK.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_addr    <= '0;
            bus_wr_data <= '0;
            wr_ptr      <= '0;
            wrapped     <= 1'b0;
            tcnt        <= '0;
        end else begin
            if (can_start && start) begin
                wr_ptr  <= '0;
                wrapped <= 1'b0;
                tcnt    <= '0;
            end
            if (accept) begin
                bus_addr    <= BASE + 32'({wr_ptr, 2'b00});
                bus_wr_data <= sample_data;
            end
            if (state == S_WRITE) begin
                tcnt <= '0;
            end
            if (state == S_ACK) begin
                if (bus_wr_ack) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (ptr_last) wrapped <= 1'b1;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end
        end
    end

endmodule
